// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with full-scan debounce
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_val,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  // Scan vector bit index is col*4 + row; returns the printed hex legend.
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h4;
      4'd2:  code = 4'h7;
      4'd3:  code = 4'h0;
      4'd4:  code = 4'h2;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h8;
      4'd7:  code = 4'hF;
      4'd8:  code = 4'h3;
      4'd9:  code = 4'h6;
      4'd10: code = 4'h9;
      4'd11: code = 4'hE;
      4'd12: code = 4'hA;
      4'd13: code = 4'hB;
      4'd14: code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [11:0]      acc;
  logic             cand_key;
  logic [3:0]       cand_code;
  logic [CNT_W-1:0] cnt;
  logic             stable_key;
  logic [3:0]       stable_code;

  logic             tick;
  logic             scan_end;
  logic [15:0]      scan_vec;
  logic [4:0]       ones;
  logic [3:0]       hit;
  logic             raw_key;
  logic [3:0]       raw_code;
  logic             match;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  // Two-flop synchronizer; idle rows read as released (all high).
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign tick     = (div == DIV_LAST);
  assign scan_end = tick && (col_idx == 2'd3);

  // Column dwell divider and column drive; the next column is driven right away so it settles for a full dwell.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      div     <= '0;
      col_idx <= 2'd0;
      col     <= 4'b1110;
    end else if (tick) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= ~(4'b0001 << (col_idx + 2'd1));
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Accumulate active-high key hits for columns 0..2; column 3 is combined live at scan end.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      acc <= '0;
    end else if (tick) begin
      case (col_idx)
        2'd0:    acc[3:0]  <= ~row_sync;
        2'd1:    acc[7:4]  <= ~row_sync;
        2'd2:    acc[11:8] <= ~row_sync;
        default: acc       <= '0;
      endcase
    end
  end

  // Classify the finished scan: exactly one hit is a key, anything else is "none".
  always_comb begin
    scan_vec = {~row_sync, acc};
    ones     = '0;
    hit      = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_vec[i]) begin
        ones = ones + 5'd1;
        hit  = 4'(i);
      end
    end
    raw_key  = (ones == 5'd1);
    raw_code = raw_key ? key_code(hit) : 4'h0;
  end

  // Debounce bookkeeping: saturating run length of identical scan results.
  always_comb begin
    match    = (raw_key == cand_key) && (raw_code == cand_code);
    cnt_next = CNT_W'(1);
    if (match) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end
    accept = (cnt_next == CNT_MAX) &&
             ((raw_key != stable_key) || (raw_code != stable_code));
  end

  // Candidate/stable state and registered key outputs, all updated on the scan-end tick.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      cand_key    <= 1'b0;
      cand_code   <= 4'h0;
      cnt         <= '0;
      stable_key  <= 1'b0;
      stable_code <= 4'h0;
      key_val     <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        cand_key  <= raw_key;
        cand_code <= raw_code;
        cnt       <= cnt_next;
        if (accept) begin
          stable_key  <= raw_key;
          stable_code <= raw_code;
          key_held    <= raw_key;
          if (raw_key) begin
            key_val   <= raw_code;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk_100mhz;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_val;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk_100mhz(clk_100mhz),
    .rst(rst),
    .row(row),
    .col(col),
    .key_val(key_val),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  // Physical keypad: pressed bit r*4+c shorts row r to column c.
  logic [15:0] pressed;
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  int n_checks;
  int n_errors;
  int n_strobe;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cycle position from elapsed cycles, scan result from 16 samples.
  int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int         m_cyc;
  logic [3:0] m_h1, m_h2;
  logic [3:0] m_samp[4];
  bit         m_cand_k, m_stab_k;
  int         m_cand_c, m_stab_c, m_cnt;
  logic [3:0] e_val, e_col;
  logic       e_valid, e_held;
  logic       rst_now;
  logic [3:0] row_now;

  task automatic model_scan_end();
    int lows, rr, cc, raw_c;
    bit raw_k;
    lows = 0; rr = 0; cc = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!m_samp[c][r]) begin lows++; rr = r; cc = c; end
    raw_k = (lows == 1);
    raw_c = raw_k ? keymap[rr*4+cc] : 0;
    if (raw_k == m_cand_k && raw_c == m_cand_c) begin
      m_cnt = (m_cnt + 1 > DB) ? DB : m_cnt + 1;
    end else begin
      m_cand_k = raw_k; m_cand_c = raw_c; m_cnt = 1;
    end
    if (m_cnt == DB && (m_cand_k != m_stab_k || m_cand_c != m_stab_c)) begin
      m_stab_k = m_cand_k; m_stab_c = m_cand_c;
      e_held = m_stab_k;
      if (m_stab_k) begin
        e_val = 4'(m_stab_c);
        e_valid = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    logic [3:0] samp;
    int idx;
    if (rst_now) begin
      m_cyc = 0; m_h1 = 4'hF; m_h2 = 4'hF;
      m_cand_k = 0; m_cand_c = 0; m_cnt = 0; m_stab_k = 0; m_stab_c = 0;
      e_val = 0; e_valid = 0; e_held = 0;
    end else begin
      e_valid = 1'b0;
      samp = m_h2; m_h2 = m_h1; m_h1 = row_now;
      if (m_cyc % SD == SD - 1) begin
        idx = (m_cyc / SD) % 4;
        m_samp[idx] = samp;
        if (idx == 3) model_scan_end();
      end
      m_cyc++;
    end
    e_col = ~(4'b0001 << ((m_cyc / SD) % 4));
  endtask

  task automatic step();
    #1;
    rst_now = rst;
    row_now = row;
    @(posedge clk_100mhz);
    model_edge();
    #1;
    check_eq("col", col, e_col);
    check_eq("key_valid", key_valid, e_valid);
    check_eq("key_val", key_val, e_val);
    check_eq("key_held", key_held, e_held);
    if (key_valid) n_strobe++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_strobe(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (key_valid) seen = 1;
    end
    check_eq(tag, seen, 1'b1);
  endtask

  int s0, drops, cyc;
  bit seen;
  logic [15:0] pat;

  initial begin
    n_checks = 0; n_errors = 0; n_strobe = 0;
    pressed = '0;
    rst = 1'b1;
    run(2);
    check_eq("reset_col", col, 4'b1110);
    check_eq("reset_val", key_val, 4'h0);
    check_eq("reset_held", key_held, 1'b0);
    rst = 1'b0;

    // Idle scanning
    s0 = n_strobe;
    run(64);
    check_eq("idle_strobes", n_strobe - s0, 0);

    // Key 5 press and release
    pressed = 16'(1) << 5;
    s0 = n_strobe;
    run(67);
    check_eq("k5_strobes", n_strobe - s0, 1);
    check_eq("k5_val", key_val, 4'h5);
    check_eq("k5_held", key_held, 1'b1);
    pressed = '0;
    s0 = n_strobe;
    run(67);
    check_eq("k5_rel_held", key_held, 1'b0);
    check_eq("k5_rel_val", key_val, 4'h5);
    check_eq("k5_rel_strobes", n_strobe - s0, 0);

    // Key 8 bouncing then steady
    s0 = n_strobe;
    for (int i = 0; i < 20; i++) begin
      pressed = (i % 2 == 0) ? (16'(1) << 9) : 16'h0;
      run(10);
    end
    pressed = 16'(1) << 9;
    run(80);
    check_eq("k8_strobes", n_strobe - s0, 1);
    check_eq("k8_val", key_val, 4'h8);

    // Keys 1 and 9 together
    pressed = (16'(1) << 0) | (16'(1) << 10);
    s0 = n_strobe;
    run(160);
    check_eq("multi_strobes", n_strobe - s0, 0);
    check_eq("multi_held", key_held, 1'b0);
    check_eq("multi_val", key_val, 4'h8);

    // 5 then directly A
    pressed = '0;
    run(67);
    pressed = 16'(1) << 5;
    wait_strobe("k5b_strobe", 80);
    check_eq("k5b_val", key_val, 4'h5);
    pressed = 16'(1) << 3;
    drops = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      if (!key_held) drops++;
      if (key_valid) seen = 1;
    end
    check_eq("kA_strobe", seen, 1'b1);
    check_eq("kA_val", key_val, 4'hA);
    check_eq("kA_held_drops", drops, 0);

    // Reset while D is accepted
    pressed = 16'(1) << 15;
    wait_strobe("kD_strobe", 80);
    check_eq("kD_val", key_val, 4'hD);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_col", col, 4'b1110);
    check_eq("rst_val", key_val, 4'h0);
    check_eq("rst_held", key_held, 1'b0);
    check_eq("rst_valid", key_valid, 1'b0);
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      step();
      cyc++;
      if (key_valid) seen = 1;
    end
    check_eq("rst_redebounce_cycles", cyc, 48);
    check_eq("rst_redebounce_val", key_val, 4'hD);

    // Random patterns including multi-key and occasional reset
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      if (kind <= 2) pat = '0;
      else if (kind <= 7) pat = 16'(1) << $urandom_range(0, 15);
      else pat = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      pressed = pat;
      run($urandom_range(8, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
